// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// Define ARB_TIMEOUT_EN to abandon an access after MAX_WAIT cycles without mem_ack.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_BUSY,
        S_D_BUSY,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_was_d;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err;
    logic              w_if_win;
    logic              w_d_win;
    logic              w_busy;
    logic              w_timeout;

    assign w_busy = (r_state == S_IF_BUSY) || (r_state == S_D_BUSY);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    // Restarts on every grant, so the count is fresh on entry to x_BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_if_win || w_d_win) begin
            r_wait_cnt <= '0;
        end else if (w_busy && !mem_ack && (r_wait_cnt != CNT_W'(MAX_WAIT))) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = w_busy && !mem_ack && (r_wait_cnt == CNT_W'(MAX_WAIT));
`else
    assign w_timeout = 1'b0 & (MAX_WAIT > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // D wins a tie unless the previous completed access was also D.
    always_comb begin
        w_next   = r_state;
        w_if_win = 1'b0;
        w_d_win  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_req && (!if_req || !r_last_was_d)) begin
                    w_d_win = 1'b1;
                    w_next  = S_D_BUSY;
                end else if (if_req) begin
                    w_if_win = 1'b1;
                    w_next   = S_IF_BUSY;
                end
            end
            S_IF_BUSY, S_D_BUSY: begin
                if (mem_ack || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rvalid  <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_err        <= 1'b0;
            r_last_was_d <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_d_win) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                    end else if (w_if_win) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                S_IF_BUSY: begin
                    if (mem_ack || w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_if_rvalid <= 1'b1;
                        r_if_rdata  <= mem_ack ? mem_rdata : '0;
                        r_err       <= !mem_ack;
                    end
                end
                S_D_BUSY: begin
                    if (mem_ack || w_timeout) begin
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_d_rvalid <= 1'b1;
                        r_d_rdata  <= (mem_ack && !r_mem_we) ? mem_rdata : '0;
                        r_err      <= !mem_ack;
                    end
                end
                S_RESP: begin
                    r_last_was_d <= r_d_rvalid;
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = w_if_win;
    assign d_gnt     = w_d_win;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;

    // The response cycle releases the pipeline even if a new request is waiting.
    assign stall = (r_state != S_RESP) && ((r_state != S_IDLE) || if_req || d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, reset/timeout sequences,
// and randomized traffic against a transaction-level memory/arbitration model.
module tb_mem_port_arbiter;

    localparam int MW = 15;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .err(err)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic ir; logic [31:0] ia;
        logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
        logic ack; logic [31:0] mrd;
        logic eig; logic edg; logic emr; logic emw; logic [31:0] ema; logic [31:0] emd;
        logic eir; logic [31:0] eird; logic edr; logic [31:0] edrd; logic est;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dd, input logic ack, input logic [31:0] mrd,
        input logic eig, input logic edg, input logic emr, input logic emw,
        input logic [31:0] ema, input logic [31:0] emd, input logic eir, input logic [31:0] eird,
        input logic edr, input logic [31:0] edrd, input logic est);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.ack = ack; v.mrd = mrd; v.eig = eig; v.edg = edg; v.emr = emr; v.emw = emw;
        v.ema = ema; v.emd = emd; v.eir = eir; v.eird = eird; v.edr = edr; v.edrd = edrd;
        v.est = est;
        return v;
    endfunction

    logic [31:0] mem_m [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    vec_t vt[$];

    bit          m_free, m_acc, m_resp, m_last_d, m_own_d, m_err;
    bit          ip, dp, ig_prev, dg_prev, e_ig, e_dg, ack_now, dw_r, c_we;
    logic [31:0] m_rdata, c_addr, c_wdata, ia_r, da_r, dd_r;
    int          m_wait;

    initial begin
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;

        // Fetch, tie-break, alternation, store and stray-ack vectors, one per cycle.
        //              ir ia      dr dw da      dd         ack mrd          eig edg emr emw ema     emd        eir eird         edr edrd         est
        vt.push_back(mk(1, 32'h100, 0, 0, 32'h0,   32'h0,       0, 32'h0,        1, 0, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 1, 0, 32'h100, 32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       1, 32'h00500093, 0, 0, 1, 0, 32'h100, 32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,       1, 32'h00500093, 0, 32'h0,        0));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 32'h0,        0));
        vt.push_back(mk(1, 32'h104, 1, 0, 32'h200, 32'h0,       0, 32'h0,        0, 1, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(1, 32'h104, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 1, 0, 32'h200, 32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(1, 32'h104, 0, 0, 32'h0,   32'h0,       1, 32'h11112222, 0, 0, 1, 0, 32'h200, 32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(1, 32'h104, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,       0, 32'h0,        1, 32'h11112222, 0));
        vt.push_back(mk(1, 32'h104, 1, 0, 32'h204, 32'h0,       0, 32'h0,        1, 0, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   1, 0, 32'h204, 32'h0,       0, 32'h0,        0, 0, 1, 0, 32'h104, 32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   1, 0, 32'h204, 32'h0,       1, 32'h0AAA0BBB, 0, 0, 1, 0, 32'h104, 32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   1, 0, 32'h204, 32'h0,       0, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,       1, 32'h0AAA0BBB, 0, 32'h0,        0));
        vt.push_back(mk(0, 32'h0,   1, 0, 32'h204, 32'h0,       0, 32'h0,        0, 1, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 1, 0, 32'h204, 32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       1, 32'h33334444, 0, 0, 1, 0, 32'h204, 32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,       0, 32'h0,        1, 32'h33334444, 0));
        vt.push_back(mk(0, 32'h0,   1, 1, 32'h40,  32'hDEADBEEF, 0, 32'h0,       0, 1, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 1, 1, 32'h40,  32'hDEADBEEF, 0, 32'h0,       0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 1, 1, 32'h40,  32'hDEADBEEF, 0, 32'h0,       0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       1, 32'h55555555, 0, 0, 1, 1, 32'h40,  32'hDEADBEEF, 0, 32'h0,       0, 32'h0,        1));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,       0, 32'h0,        1, 32'h0,        0));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       1, 32'h77777777, 0, 0, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 32'h0,        0));
        vt.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,       0, 32'h0,        0, 32'h0,        0));

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #4;
        chk1("reset mem_req", mem_req, 1'b0);
        chk1("reset mem_we", mem_we, 1'b0);
        chk32("reset mem_addr", mem_addr, 32'h0);
        chk32("reset mem_wdata", mem_wdata, 32'h0);
        chk1("reset if_rvalid", if_rvalid, 1'b0);
        chk1("reset d_rvalid", d_rvalid, 1'b0);
        chk32("reset if_rdata", if_rdata, 32'h0);
        chk32("reset d_rdata", d_rdata, 32'h0);
        chk1("reset err", err, 1'b0);
        chk1("reset stall", stall, 1'b0);
        next_cycle();

        foreach (vt[i]) begin
            if_req = vt[i].ir; if_addr = vt[i].ia;
            d_req = vt[i].dr; d_we = vt[i].dw; d_addr = vt[i].da; d_wdata = vt[i].dd;
            mem_ack = vt[i].ack; mem_rdata = vt[i].mrd;
            #4;
            chk1($sformatf("v%0d if_gnt", i), if_gnt, vt[i].eig);
            chk1($sformatf("v%0d d_gnt", i), d_gnt, vt[i].edg);
            chk1($sformatf("v%0d mem_req", i), mem_req, vt[i].emr);
            if (vt[i].emr) begin
                chk1($sformatf("v%0d mem_we", i), mem_we, vt[i].emw);
                chk32($sformatf("v%0d mem_addr", i), mem_addr, vt[i].ema);
                if (vt[i].emw) chk32($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].emd);
            end
            chk1($sformatf("v%0d if_rvalid", i), if_rvalid, vt[i].eir);
            if (vt[i].eir) chk32($sformatf("v%0d if_rdata", i), if_rdata, vt[i].eird);
            chk1($sformatf("v%0d d_rvalid", i), d_rvalid, vt[i].edr);
            if (vt[i].edr) chk32($sformatf("v%0d d_rdata", i), d_rdata, vt[i].edrd);
            chk1($sformatf("v%0d stall", i), stall, vt[i].est);
            chk1($sformatf("v%0d err", i), err, 1'b0);
            next_cycle();
        end
        if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;

        // Reset while D_BUSY: access abandoned immediately, no response afterwards
        d_req = 1; d_addr = 32'h80;
        #4 chk1("rstbusy d_gnt", d_gnt, 1'b1);
        next_cycle();
        d_req = 0;
        #1 chk1("rstbusy mem_req before", mem_req, 1'b1);
        #1 rst = 1;
        #1;
        chk1("rstbusy mem_req async", mem_req, 1'b0);
        chk1("rstbusy stall", stall, 1'b0);
        next_cycle();
        rst = 0; mem_ack = 1; mem_rdata = 32'h99;
        for (int k = 0; k < 3; k++) begin
            #4;
            chk1($sformatf("rstbusy d_rvalid %0d", k), d_rvalid, 1'b0);
            chk1($sformatf("rstbusy if_rvalid %0d", k), if_rvalid, 1'b0);
            chk1($sformatf("rstbusy mem_req %0d", k), mem_req, 1'b0);
            next_cycle();
            mem_ack = 0;
        end
        if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h84;
        #4;
        chk1("rstbusy tie d_gnt", d_gnt, 1'b1);
        chk1("rstbusy tie if_gnt", if_gnt, 1'b0);
        next_cycle();
        if_req = 0; d_req = 0; mem_ack = 1; mem_rdata = 32'h1234;
        next_cycle();
        mem_ack = 0;
        #4;
        chk1("rstbusy resp d_rvalid", d_rvalid, 1'b1);
        chk32("rstbusy resp d_rdata", d_rdata, 32'h1234);
        next_cycle();

        // Memory never acknowledges
        d_req = 1; d_we = 0; d_addr = 32'hC0;
        #4 chk1("noack d_gnt", d_gnt, 1'b1);
        next_cycle();
        d_req = 0;
        for (int k = 1; k <= 16; k++) begin
            #4;
            chk1($sformatf("noack mem_req %0d", k), mem_req, 1'b1);
            chk1($sformatf("noack err %0d", k), err, 1'b0);
            chk1($sformatf("noack d_rvalid %0d", k), d_rvalid, 1'b0);
            next_cycle();
        end
        if (TO_EN) begin
            #4;
            chk1("timeout d_rvalid", d_rvalid, 1'b1);
            chk1("timeout err", err, 1'b1);
            chk32("timeout d_rdata", d_rdata, 32'h0);
            chk1("timeout mem_req", mem_req, 1'b0);
            next_cycle();
            #4;
            chk1("timeout err pulse", err, 1'b0);
            chk1("timeout rvalid pulse", d_rvalid, 1'b0);
            next_cycle();
            // Ack on the deadline cycle completes normally
            d_req = 1; d_addr = 32'hC4;
            #4 chk1("deadline d_gnt", d_gnt, 1'b1);
            next_cycle();
            d_req = 0;
            for (int k = 1; k <= 15; k++) begin
                #4 chk1($sformatf("deadline mem_req %0d", k), mem_req, 1'b1);
                next_cycle();
            end
            mem_ack = 1; mem_rdata = 32'hCAFE0001;
            next_cycle();
            mem_ack = 0;
            #4;
            chk1("deadline d_rvalid", d_rvalid, 1'b1);
            chk1("deadline err", err, 1'b0);
            chk32("deadline d_rdata", d_rdata, 32'hCAFE0001);
            next_cycle();
        end else begin
            for (int k = 17; k <= 20; k++) begin
                #4;
                chk1($sformatf("noack hold mem_req %0d", k), mem_req, 1'b1);
                chk1($sformatf("noack hold err %0d", k), err, 1'b0);
                next_cycle();
            end
            mem_ack = 1; mem_rdata = 32'hCAFE0002;
            next_cycle();
            mem_ack = 0;
            #4;
            chk1("noack late d_rvalid", d_rvalid, 1'b1);
            chk32("noack late d_rdata", d_rdata, 32'hCAFE0002);
            next_cycle();
        end

        // Randomized traffic against the transaction-level model
        rst = 1;
        next_cycle();
        rst = 0;
        m_free = 1; m_acc = 0; m_resp = 0; m_last_d = 0; m_own_d = 0; m_err = 0;
        ip = 0; dp = 0; ig_prev = 0; dg_prev = 0; m_wait = 0;
        m_rdata = 0; c_addr = 0; c_wdata = 0; c_we = 0;
        ia_r = 0; da_r = 0; dd_r = 0; dw_r = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!ip && !ig_prev && ($urandom_range(0, 2) == 0)) begin
                ip = 1;
                ia_r = 32'($urandom_range(0, 7)) << 2;
            end
            if (!dp && !dg_prev && ($urandom_range(0, 2) == 0)) begin
                dp = 1;
                dw_r = 1'($urandom_range(0, 1));
                da_r = 32'($urandom_range(0, 7)) << 2;
                dd_r = $urandom;
            end
            if_req = ip; if_addr = ip ? ia_r : $urandom;
            d_req = dp; d_we = dp ? dw_r : 1'($urandom_range(0, 1));
            d_addr = dp ? da_r : $urandom; d_wdata = dp ? dd_r : $urandom;
            ack_now = ($urandom_range(0, 2) == 0);
            mem_ack = ack_now;
            mem_rdata = (m_acc && !c_we) ? mem_rd(c_addr) : $urandom;
            #4;
            e_ig = 0; e_dg = 0;
            if (m_free) begin
                if (dp && (!ip || !m_last_d)) e_dg = 1;
                else if (ip) e_ig = 1;
            end
            chk1("rnd if_gnt", if_gnt, e_ig);
            chk1("rnd d_gnt", d_gnt, e_dg);
            chk1("rnd mem_req", mem_req, m_acc);
            if (m_acc) begin
                chk32("rnd mem_addr", mem_addr, c_addr);
                chk1("rnd mem_we", mem_we, c_we);
                if (c_we) chk32("rnd mem_wdata", mem_wdata, c_wdata);
            end
            chk1("rnd if_rvalid", if_rvalid, m_resp && !m_own_d);
            chk1("rnd d_rvalid", d_rvalid, m_resp && m_own_d);
            if (m_resp && !m_own_d) chk32("rnd if_rdata", if_rdata, m_rdata);
            if (m_resp && m_own_d) chk32("rnd d_rdata", d_rdata, m_rdata);
            chk1("rnd err", err, m_resp && m_err);
            chk1("rnd stall", stall, !m_resp && (!m_free || ip || dp));
            ig_prev = e_ig; dg_prev = e_dg;
            if (m_resp) begin
                m_last_d = m_own_d; m_resp = 0; m_free = 1;
            end else if (e_ig || e_dg) begin
                m_free = 0; m_acc = 1; m_own_d = e_dg; m_wait = 0;
                c_we = e_dg ? dw_r : 1'b0;
                c_addr = e_dg ? da_r : ia_r;
                c_wdata = e_dg ? dd_r : 32'h0;
                if (e_dg) dp = 0; else ip = 0;
            end else if (m_acc) begin
                if (ack_now) begin
                    m_acc = 0; m_resp = 1; m_err = 0;
                    if (c_we) begin
                        mem_m[c_addr] = c_wdata;
                        m_rdata = 32'h0;
                    end else begin
                        m_rdata = mem_rd(c_addr);
                    end
                end else if (TO_EN && m_wait == MW) begin
                    m_acc = 0; m_resp = 1; m_err = 1; m_rdata = 32'h0;
                end else begin
                    m_wait++;
                end
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
